uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- UART serial transmitter; the transmit-side counterpart to the 16x-oversampling receive path.
- Consumes the sample tick `s_tick` from the shared baud tick generator. Each bit is held for 16 ticks.
- Serialises a DBIT-wide word LSB-first as: start bit, data bits, optional parity, stop.
- Sits between the SHA-256 result/host logic and the board TX pin.

Parameters:
- DBIT, 8, number of data bits per frame (5..9).
- SB_TICK, 16, ticks spent in the stop state (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- OS_TICK, 16, oversampling ticks per bit for start, data and parity bits (must match the receiver).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- tx_start  in  1  single-cycle request to send `din`; honoured only in IDLE.
- s_tick  in  1  baud sample tick, one clk cycle wide.
- din  in  DBIT  data word, sampled in the cycle `tx_start` is accepted.
- tx_busy  out  1  high from the accepted `tx_start` until return to IDLE.
- tx_done_tick  out  1  one-clk pulse when the stop period completes.
- tx  out  1  serial line; idle-high.

Behaviour:
- Reset, asynchronous:
  - state=IDLE, tx=1, tx_busy=0, tx_done_tick=0.
  - Tick counter, bit counter and shift register all 0.
  - Reset mid-frame aborts the frame; tx returns to 1 immediately with no partial stop and no done pulse.
- Registered line output: tx comes from a flop (tx_reg), so no glitches.
- Counters:
  - Tick counter s_cnt is width clog2(max(OS_TICK,SB_TICK)).
  - Bit counter n_cnt is width clog2(DBIT).
  - s_cnt advances only on cycles with s_tick=1.
- States:
  - IDLE:
    - tx=1.
    - On tx_start: load shift reg ← din, s_cnt←0, go START, tx_busy←1.
    - An s_tick in the same cycle is not counted.
  - START:
    - tx=0.
    - On s_tick: if s_cnt==OS_TICK-1, then s_cnt←0, n_cnt←0, go DATA. Otherwise s_cnt++.
  - DATA:
    - tx=shreg[0].
    - On s_tick with s_cnt==OS_TICK-1: shreg shifts right, s_cnt←0.
    - If n_cnt==DBIT-1, go PARITY (when enabled) else STOP. Otherwise n_cnt++.
  - PARITY (macro only):
    - tx=parity bit.
    - On s_tick with s_cnt==OS_TICK-1: s_cnt←0, go STOP.
  - STOP:
    - tx=1.
    - On s_tick with s_cnt==SB_TICK-1: go IDLE, tx_done_tick=1 for exactly that clk cycle, tx_busy←0.
- Timing:
  - Latency: tx falls the clk cycle after tx_start is accepted.
  - Frame length is (1+DBIT)·OS_TICK + SB_TICK ticks, plus OS_TICK when parity is enabled.
- tx_start while busy, including the cycle tx_done_tick is high: ignored. There is no queue.
- Back-to-back frames: the earliest next accept is the first IDLE cycle after tx_done_tick, which gives the minimum one-clk gap.
- din changes after accept have no effect on the frame in flight.
- s_tick absent: the FSM holds its state and tx indefinitely.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds the PARITY state after the last data bit.
  - Parity bit = XOR of the din word latched at accept, i.e. even parity (total count of ones including the parity bit is even).
  - The parity bit is computed at accept and held in a flop.
- Undefined:
  - No PARITY state and no parity flop.
  - DATA goes directly to STOP.

Decomposition:
- Shared package uart_pkg:
  - Enum tx_state_t {IDLE, START, DATA, PARITY, STOP}; PARITY is present regardless of the macro so the encoding is stable.
  - Localparam OS_TICK_DEFAULT=16.
  - Localparams for the stop-tick presets (16/24/32).
- No sub-module; the FSM, shift register and counters form one module.
- Benches instantiate the existing tick generator alongside this block.

Test Plan:
- Reset, then idle with s_tick toggling → tx=1, tx_busy=0, no done pulses for 1000 cycles.
- s_tick every clk; tx_start with din=0xA5 → line bits, each 16 clk, are 0 | 1,0,1,0,0,1,0,1 | 1. tx_done_tick fires exactly 160 clk after accept. With UART_TX_PARITY_EN, parity bit=0 is inserted and done fires at 176 clk.
- Tick generator with M=28 drives s_tick; din=0x3C → each bit lasts 16·28=448 clk. Receiver loopback returns 0x3C.
- tx_start pulsed mid-frame with din=0xFF, then again the cycle after done with din=0x00 → first frame unaffected, 0xFF dropped, 0x00 frame starts with a 1-clk gap.
- Reset asserted during DATA bit 3 → tx=1 in the same cycle, tx_busy=0, no tx_done_tick. A following tx_start with din=0x55 sends a clean frame.
- SB_TICK=32 with din=0x01 → stop high for 32 ticks, done at 176 ticks after accept.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and presets for the UART transmit path.
// Frame-state encoding is fixed whether or not parity is built in.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int OS_TICK_DEFAULT = 16;

  localparam int SB_TICK_1   = 16;
  localparam int SB_TICK_1P5 = 24;
  localparam int SB_TICK_2   = 32;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx.sv
// uart_tx: oversampled UART transmitter, LSB first, registered line.
// Define UART_TX_PARITY_EN to append an even-parity bit before stop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = SB_TICK_1,
  parameter int OS_TICK = OS_TICK_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tx_start,
  input  logic            s_tick,
  input  logic [DBIT-1:0] din,
  output logic            tx_busy,
  output logic            tx_done_tick,
  output logic            tx
);

  localparam int SW = cnt_w(max_i(OS_TICK, SB_TICK));
  localparam int NW = cnt_w(DBIT);

  localparam logic [SW-1:0] OS_LAST = SW'(OS_TICK - 1);
  localparam logic [SW-1:0] SB_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST  = NW'(DBIT - 1);

  tx_state_t       state_q, state_d;
  logic [SW-1:0]   s_cnt_q, s_cnt_d;
  logic [NW-1:0]   n_cnt_q, n_cnt_d;
  logic [DBIT-1:0] sh_q, sh_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            done;

`ifdef UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      s_cnt_q <= '0;
      n_cnt_q <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_cnt_q <= n_cnt_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    sh_d    = sh_q;
    done    = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (tx_start) begin
          sh_d    = din;
          s_cnt_d = '0;
          state_d = START;
`ifdef UART_TX_PARITY_EN
          par_d   = ^din;
`endif
        end
      end
      START: begin
        if (s_tick) begin
          if (s_cnt_q == OS_LAST) begin
            s_cnt_d = '0;
            n_cnt_d = '0;
            state_d = DATA;
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_cnt_q == OS_LAST) begin
            sh_d    = sh_q >> 1;
            s_cnt_d = '0;
            if (n_cnt_q == N_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_cnt_d = n_cnt_q + NW'(1);
            end
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end
      PARITY: begin
`ifdef UART_TX_PARITY_EN
        if (s_tick) begin
          if (s_cnt_q == OS_LAST) begin
            s_cnt_d = '0;
            state_d = STOP;
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
`else
        state_d = IDLE;
`endif
      end
      STOP: begin
        if (s_tick) begin
          if (s_cnt_q == SB_LAST) begin
            s_cnt_d = '0;
            state_d = IDLE;
            done    = 1'b1;
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is decoded from the next state so tx lands in a flop.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  assign tx           = tx_q;
  assign tx_busy      = busy_q;
  assign tx_done_tick = done;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized and directed checks of uart_tx against a
// tick-counting frame model; a second instance runs with 2 stop bits.
module tb_uart_tx;

  localparam int DBIT = 8;
  localparam int OS   = 16;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FRAME = (1 + DBIT) * OS + (PAR ? OS : 0) + 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_start = 1'b0;
  logic       s_tick = 1'b0;
  logic [7:0] din = 8'h00;
  logic       tx, tx_busy, tx_done_tick;

  logic       tx_start2 = 1'b0;
  logic       s_tick2 = 1'b1;
  logic [7:0] din2 = 8'h00;
  logic       tx2, tx_busy2, tx_done_tick2;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int a0 = 0;
  int tick_mode = 0;
  int tick_m = 1;
  int tick_cnt = 0;
  logic line_s [0:15];

  uart_tx #(.DBIT(8), .SB_TICK(16), .OS_TICK(16)) dut (
    .clk(clk), .reset(reset), .tx_start(tx_start), .s_tick(s_tick),
    .din(din), .tx_busy(tx_busy), .tx_done_tick(tx_done_tick), .tx(tx)
  );

  uart_tx #(.DBIT(8), .SB_TICK(32), .OS_TICK(16)) dut2 (
    .clk(clk), .reset(reset), .tx_start(tx_start2), .s_tick(s_tick2),
    .din(din2), .tx_busy(tx_busy2), .tx_done_tick(tx_done_tick2), .tx(tx2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    case (tick_mode)
      1: s_tick <= 1'b1;
      2: begin
        if (tick_cnt >= tick_m - 1) begin
          tick_cnt <= 0;
          s_tick   <= 1'b1;
        end else begin
          tick_cnt <= tick_cnt + 1;
          s_tick   <= 1'b0;
        end
      end
      3: s_tick <= ($urandom_range(0, 2) == 0);
      default: s_tick <= 1'b0;
    endcase
  end

  // Frame model: only "busy" and the count of ticks seen since accept.
  bit         m_busy;
  int         m_t;
  logic [7:0] m_data;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_t    <= 0;
    end else if (m_busy) begin
      if (s_tick) begin
        if (m_t == FRAME - 1) m_busy <= 1'b0;
        m_t <= m_t + 1;
      end
    end else if (tx_start) begin
      m_busy <= 1'b1;
      m_t    <= 0;
      m_data <= din;
    end
  end

  function automatic logic exp_tx();
    int pos;
    if (!m_busy) return 1'b1;
    pos = m_t / OS;
    if (pos == 0) return 1'b0;
    if (pos <= DBIT) return m_data[pos-1];
    if (PAR && pos == DBIT + 1) return ^m_data;
    return 1'b1;
  endfunction

  function automatic logic exp_done();
    return m_busy && s_tick && (m_t == FRAME - 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      chk("tx", {31'd0, tx}, {31'd0, exp_tx()});
      chk("busy", {31'd0, tx_busy}, {31'd0, m_busy});
      chk("done", {31'd0, tx_done_tick}, {31'd0, exp_done()});
    end
  end

  task automatic send(input logic [7:0] d);
    @(posedge clk);
    #1;
    din      = d;
    tx_start = 1'b1;
    a0       = cyc;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
  endtask

  task automatic run_frame(input int lim, output int done_off);
    int o;
    done_off = -1;
    for (int i = 0; i < lim && done_off < 0; i++) begin
      @(negedge clk);
      o = cyc - a0;
      if (o % OS == OS / 2 && o / OS < 16) line_s[o/OS] = tx;
      if (tx_done_tick) done_off = o;
    end
  endtask

  task automatic check_line(input string nm, input logic [15:0] exp,
                            input int nb);
    for (int j = 0; j < nb; j++)
      chk(nm, {31'd0, line_s[j]}, {31'd0, exp[j]});
  endtask

  initial begin
    int off, cnt, a1, t0, b0;
    logic [7:0] rx;
    logic tx_hold;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, tx_busy}, 32'd0);
    chk("rst_done", {31'd0, tx_done_tick}, 32'd0);
    reset = 1'b0;

    tick_mode = 3;
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx_done_tick) cnt++;
    end
    chk("idle_done_cnt", cnt, 0);
    chk("idle_tx", {31'd0, tx}, 32'd1);

    tick_mode = 1;
    repeat (3) @(posedge clk);
    send(8'hA5);
    run_frame(400, off);
    chk("a5_done_off", off, PAR ? 176 : 160);
    if (PAR) check_line("a5_line", {5'd0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11);
    else check_line("a5_line", {6'd0, 1'b1, 8'hA5, 1'b0}, 10);

    repeat (4) @(posedge clk);
    send(8'h5A);
    for (int i = 0; i < 48; i++) @(posedge clk);
    #1;
    din = 8'hFF;
    tx_start = 1'b1;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    off = -1;
    for (int i = 0; i < 400 && off < 0; i++) begin
      @(negedge clk);
      if (tx_done_tick) off = cyc - a0;
    end
    chk("5a_done_off", off, PAR ? 176 : 160);
    din = 8'hFF;
    tx_start = 1'b1;
    @(posedge clk);
    #1;
    din = 8'h00;
    a1 = cyc;
    chk("gap_idle_tx", {31'd0, tx}, 32'd1);
    chk("gap_accept_cyc", a1 - a0, (PAR ? 176 : 160) + 1);
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    chk("gap_fall_tx", {31'd0, tx}, 32'd0);
    a0 = a1;
    run_frame(400, off);
    chk("00_done_off", off, PAR ? 176 : 160);
    check_line("00_line", {7'd0, 1'b1, 8'h00, 1'b0}, 10);

    repeat (4) @(posedge clk);
    send(8'h33);
    for (int i = 0; i < 400 && (cyc - a0) < 70; i++) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_tx", {31'd0, tx}, 32'd1);
    chk("mid_rst_busy", {31'd0, tx_busy}, 32'd0);
    chk("mid_rst_done", {31'd0, tx_done_tick}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    send(8'h55);
    run_frame(400, off);
    chk("55_done_off", off, PAR ? 176 : 160);
    if (PAR) check_line("55_line", {5'd0, 1'b1, 1'b0, 8'h55, 1'b0}, 11);
    else check_line("55_line", {6'd0, 1'b1, 8'h55, 1'b0}, 10);

    tick_m = 28;
    tick_mode = 2;
    repeat (40) @(posedge clk);
    send(8'h3C);
    t0 = -1;
    for (int i = 0; i < 100 && t0 < 0; i++) begin
      @(negedge clk);
      if (!tx) t0 = cyc;
    end
    chk("3c_fall_cyc", t0 - a0, 1);
    rx = 8'h00;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 6000 && cyc < t0 + 448 * (k + 1) + 224; i++)
        @(negedge clk);
      rx[k] = tx;
    end
    chk("3c_loopback", {24'd0, rx}, 32'h3C);
    off = -1;
    for (int i = 0; i < 6000 && off < 0; i++) begin
      @(negedge clk);
      if (tx_done_tick) off = cyc;
    end
    chk("3c_done_seen", {31'd0, off > 0}, 32'd1);

    tick_mode = 3;
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk);
      #1;
      tx_start = ($urandom_range(0, 29) == 0);
      din = 8'($urandom);
    end
    tx_start = 1'b0;
    for (int i = 0; i < 2000 && tx_busy; i++) @(negedge clk);
    chk("rand_idle", {31'd0, tx_busy}, 32'd0);

    send(8'hC3);
    repeat (100) @(posedge clk);
    #1;
    tick_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    tx_hold = tx;
    repeat (300) @(posedge clk);
    #1;
    chk("hold_tx", {31'd0, tx}, {31'd0, tx_hold});
    chk("hold_busy", {31'd0, tx_busy}, 32'd1);
    tick_mode = 3;
    for (int i = 0; i < 3000 && tx_busy; i++) @(negedge clk);
    chk("hold_resume", {31'd0, tx_busy}, 32'd0);

    @(posedge clk);
    #1;
    din2 = 8'h01;
    tx_start2 = 1'b1;
    b0 = cyc;
    @(posedge clk);
    #1;
    tx_start2 = 1'b0;
    off = -1;
    for (int i = 0; i < 400 && off < 0; i++) begin
      @(negedge clk);
      if (cyc - b0 == 8) chk("sb2_start", {31'd0, tx2}, 32'd0);
      if (cyc - b0 == 24) chk("sb2_bit0", {31'd0, tx2}, 32'd1);
      if (cyc - b0 == 144) chk("sb2_bit7", {31'd0, tx2}, 32'd0);
      if (cyc - b0 == 170) chk("sb2_stop", {31'd0, tx2}, 32'd1);
      if (tx_done_tick2) off = cyc - b0;
    end
    chk("sb2_done_off", off, PAR ? 192 : 176);
    @(negedge clk);
    chk("sb2_busy_after", {31'd0, tx_busy2}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
